// File: rtl/cplx_seq_pkg.sv
// Encodings, FSM states and branch-mask helper shared by the complex-ALU
// mul/div sequencer and its testbench.
package cplx_seq_pkg;

  localparam int CKPT_W     = 8;
  localparam int CKPT_LOG_W = 3;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  // IDLE arbitrate | LAUNCH start pulse | BUSY await done | DRAIN discard | HOLD present result
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DRAIN,
    S_HOLD
  } state_e;

  function automatic logic [CKPT_W-1:0] mask_clr(input logic [CKPT_W-1:0]     mask,
                                                 input logic [CKPT_LOG_W-1:0] id);
    logic [CKPT_W-1:0] bit_w;
    bit_w     = '0;
    bit_w[id] = 1'b1;
    return mask & ~bit_w;
  endfunction

endpackage

// File: rtl/complex_alu_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves past the granted lane
// only when a grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ptr_q <= 1'b0;
    else if (advance && |req)  ptr_q <= gnt[0];
  end

endmodule

// File: rtl/complex_alu_sequencer.sv
// Shares one multi-cycle mul/div unit between two complex-ALU issue lanes:
// round-robin grant, launch, result capture, branch-mask tracking and squash.
module complex_alu_sequencer
  import cplx_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 20,
  parameter int CKPT     = CKPT_W,
  parameter int CKPT_LOG = CKPT_LOG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid_i,
  input  logic [1:0]          req0_op_i,
  input  logic [DATA_W-1:0]   req0_a_i,
  input  logic [DATA_W-1:0]   req0_b_i,
  input  logic [CKPT-1:0]     req0_mask_i,
  input  logic [TAG_W-1:0]    req0_tag_i,
  output logic                req0_ready_o,
  input  logic                req1_valid_i,
  input  logic [1:0]          req1_op_i,
  input  logic [DATA_W-1:0]   req1_a_i,
  input  logic [DATA_W-1:0]   req1_b_i,
  input  logic [CKPT-1:0]     req1_mask_i,
  input  logic [TAG_W-1:0]    req1_tag_i,
  output logic                req1_ready_o,
  input  logic                ctrlVerified_i,
  input  logic                ctrlMispredict_i,
  input  logic [CKPT_LOG-1:0] ctrlSMTid_i,
  output logic                unit_start_o,
  output logic [1:0]          unit_op_o,
  output logic [DATA_W-1:0]   unit_a_o,
  output logic [DATA_W-1:0]   unit_b_o,
  input  logic                unit_done_i,
  input  logic [2*DATA_W-1:0] unit_result_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*DATA_W-1:0] out_result_o,
  output logic [TAG_W-1:0]    out_tag_o,
  output logic [CKPT-1:0]     out_mask_o
);

  state_e              state_q;
  logic                start_q, valid_q;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [CKPT-1:0]     mask_q;
  logic [2*DATA_W-1:0] result_q;

  logic                idle_w, clr_w, kill_held_w, kill_req_w;
  logic [1:0]          req_w, gnt_w;
  logic [1:0]          sel_op_w;
  logic [DATA_W-1:0]   sel_a_w, sel_b_w;
  logic [CKPT-1:0]     sel_mask_w;
  logic [TAG_W-1:0]    sel_tag_w;

  assign idle_w = (state_q == S_IDLE);
  assign req_w  = {req1_valid_i, req0_valid_i} & {2{idle_w}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_w),
    .advance (idle_w),
    .gnt     (gnt_w)
  );

  // Gated with reset so ready reads 0 while reset is held, even with requests pending.
  assign req0_ready_o = reset & gnt_w[0];
  assign req1_ready_o = reset & gnt_w[1];

  assign sel_op_w   = gnt_w[1] ? req1_op_i   : req0_op_i;
  assign sel_a_w    = gnt_w[1] ? req1_a_i    : req0_a_i;
  assign sel_b_w    = gnt_w[1] ? req1_b_i    : req0_b_i;
  assign sel_mask_w = gnt_w[1] ? req1_mask_i : req0_mask_i;
  assign sel_tag_w  = gnt_w[1] ? req1_tag_i  : req0_tag_i;

  assign clr_w       = ctrlVerified_i & ~ctrlMispredict_i;
  assign kill_held_w = ctrlVerified_i & ctrlMispredict_i & mask_q[ctrlSMTid_i];
  assign kill_req_w  = ctrlVerified_i & ctrlMispredict_i & sel_mask_w[ctrlSMTid_i];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (!idle_w && clr_w) mask_q <= mask_clr(mask_q, ctrlSMTid_i);
      case (state_q)
        S_IDLE: begin
          if (|gnt_w && !kill_req_w) begin
            op_q    <= sel_op_w;
            a_q     <= sel_a_w;
            b_q     <= sel_b_w;
            tag_q   <= sel_tag_w;
            mask_q  <= clr_w ? mask_clr(sel_mask_w, ctrlSMTid_i) : sel_mask_w;
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= kill_held_w ? S_DRAIN : S_BUSY;
        S_BUSY: begin
          // A done that coincides with the kill is consumed here, so no drain needed.
          if (kill_held_w) begin
            state_q <= unit_done_i ? S_IDLE : S_DRAIN;
          end else if (unit_done_i) begin
            result_q <= unit_result_i;
            valid_q  <= 1'b1;
            state_q  <= S_HOLD;
          end
        end
        S_DRAIN: if (unit_done_i) state_q <= S_IDLE;
        S_HOLD: begin
          if (kill_held_w || out_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unit_start_o = start_q;
  assign unit_op_o    = op_q;
  assign unit_a_o     = a_q;
  assign unit_b_o     = b_q;
  assign out_valid_o  = valid_q;
  assign out_result_o = result_q;
  assign out_tag_o    = tag_q;
  assign out_mask_o   = mask_q;

  a_no_stray_done: assert property (@(posedge clk) disable iff (!reset)
    !(unit_done_i && (idle_w || state_q == S_HOLD)));

endmodule

// File: tb/tb_complex_alu_sequencer.sv
// Self-checking bench for complex_alu_sequencer: vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_complex_alu_sequencer;
  import cplx_seq_pkg::*;

  localparam int DW = 32;
  localparam int TW = 20;
  localparam int CK = 8;
  localparam int CL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid_i, req1_valid_i;
  logic [1:0]    req0_op_i, req1_op_i;
  logic [DW-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [CK-1:0] req0_mask_i, req1_mask_i;
  logic [TW-1:0] req0_tag_i, req1_tag_i;
  logic          req0_ready_o, req1_ready_o;
  logic          ctrlVerified_i, ctrlMispredict_i;
  logic [CL-1:0] ctrlSMTid_i;
  logic          unit_start_o;
  logic [1:0]    unit_op_o;
  logic [DW-1:0] unit_a_o, unit_b_o;
  logic          unit_done_i;
  logic [2*DW-1:0] unit_result_i;
  logic          out_valid_o, out_ready_i;
  logic [2*DW-1:0] out_result_o;
  logic [TW-1:0] out_tag_o;
  logic [CK-1:0] out_mask_o;

  always #5 clk = ~clk;

  complex_alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_op_i(req0_op_i), .req0_a_i(req0_a_i),
    .req0_b_i(req0_b_i), .req0_mask_i(req0_mask_i), .req0_tag_i(req0_tag_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_op_i(req1_op_i), .req1_a_i(req1_a_i),
    .req1_b_i(req1_b_i), .req1_mask_i(req1_mask_i), .req1_tag_i(req1_tag_i),
    .req1_ready_o(req1_ready_o),
    .ctrlVerified_i(ctrlVerified_i), .ctrlMispredict_i(ctrlMispredict_i),
    .ctrlSMTid_i(ctrlSMTid_i),
    .unit_start_o(unit_start_o), .unit_op_o(unit_op_o), .unit_a_o(unit_a_o),
    .unit_b_o(unit_b_o), .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_result_o(out_result_o),
    .out_tag_o(out_tag_o), .out_mask_o(out_mask_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int u_cnt  = 0;
  int u_lat  = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural mul/div: signed/unsigned product, {remainder, quotient} for divides.
  function automatic logic [63:0] mdu(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      default: if (b != 0) r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Cycle boundary: advance past the edge and run the mul/div unit model.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    unit_done_i      = 1'b0;
    ctrlVerified_i   = 1'b0;
    ctrlMispredict_i = 1'b0;
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        unit_done_i   = 1'b1;
        unit_result_i = mdu(unit_op_o, unit_a_o, unit_b_o);
      end
    end
  endtask

  task automatic samp();
    @(negedge clk);
    if (unit_start_o) u_cnt = u_lat;
  endtask

  task automatic idle_inputs();
    req0_valid_i = 0; req0_op_i = 0; req0_a_i = 0; req0_b_i = 0; req0_mask_i = 0; req0_tag_i = 0;
    req1_valid_i = 0; req1_op_i = 0; req1_a_i = 0; req1_b_i = 0; req1_mask_i = 0; req1_tag_i = 0;
    ctrlVerified_i = 0; ctrlMispredict_i = 0; ctrlSMTid_i = 0;
    unit_done_i = 0; unit_result_i = 0; out_ready_i = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    u_cnt = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic drive_req(input int lane, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [7:0] m, input logic [19:0] t);
    if (lane == 0) begin
      req0_valid_i = 1; req0_op_i = op; req0_a_i = a; req0_b_i = b; req0_mask_i = m; req0_tag_i = t;
    end else begin
      req1_valid_i = 1; req1_op_i = op; req1_a_i = a; req1_b_i = b; req1_mask_i = m; req1_tag_i = t;
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " ready0"}, 64'(req0_ready_o), 64'd0);
    check({nm, " ready1"}, 64'(req1_ready_o), 64'd0);
    check({nm, " start"},  64'(unit_start_o), 64'd0);
    check({nm, " op"},     64'(unit_op_o), 64'd0);
    check({nm, " a"},      64'(unit_a_o), 64'd0);
    check({nm, " b"},      64'(unit_b_o), 64'd0);
    check({nm, " valid"},  64'(out_valid_o), 64'd0);
    check({nm, " result"}, out_result_o, 64'd0);
    check({nm, " tag"},    64'(out_tag_o), 64'd0);
    check({nm, " mask"},   64'(out_mask_o), 64'd0);
  endtask

  typedef struct {
    int          lane;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [7:0]  mask;
    logic [19:0] tag;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[6];

  // Reference-model state for the randomized run.
  int          mrr, g, st_cyc, wait_n, both_cnt, rw;
  bit          fl, dead, res_av, kill, done_now;
  logic [1:0]  mop;
  logic [31:0] ma, mb, ra, rb;
  logic [19:0] mtag;
  logic [7:0]  mmask, rmask;
  logic [63:0] mres, held;
  int          grants[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{0, 2'b00, 32'd7,          32'd6, 3, 8'h81, 20'h12345, 64'd42};
    tv[1] = '{1, 2'b01, 32'hFFFF_FFFF,  32'd2, 1, 8'h00, 20'h00ABC, 64'h0000_0001_FFFF_FFFE};
    tv[2] = '{0, 2'b00, 32'hFFFF_FFFD,  32'd5, 2, 8'h10, 20'hFFFFF, 64'hFFFF_FFFF_FFFF_FFF1};
    tv[3] = '{1, 2'b10, 32'd100,        32'd7, 4, 8'h42, 20'h00001, 64'h0000_0002_0000_000E};
    tv[4] = '{0, 2'b10, 32'hFFFF_FFF9,  32'd2, 2, 8'h08, 20'h55555, 64'hFFFF_FFFF_FFFF_FFFD};
    tv[5] = '{1, 2'b11, 32'hFFFF_FFFF,  32'd2, 5, 8'hFF, 20'hAAAAA, 64'h0000_0001_7FFF_FFFF};

    // Reset state, with a request pending to show ready is held low.
    reset = 1'b0;
    idle_inputs();
    req0_valid_i = 1;
    #1 check_all_zero("reset");
    do_reset();

    // Vector table: single ops with latency, result, tag and mask checks.
    for (int i = 0; i < 6; i++) begin
      u_lat = tv[i].lat;
      tick();
      drive_req(tv[i].lane, tv[i].op, tv[i].a, tv[i].b, tv[i].mask, tv[i].tag);
      samp();
      check($sformatf("vec%0d ready", i), 64'(tv[i].lane == 0 ? req0_ready_o : req1_ready_o), 64'd1);
      st_cyc = cyc;
      tick();
      req0_valid_i = 0; req1_valid_i = 0;
      samp();
      check($sformatf("vec%0d start", i), 64'(unit_start_o), 64'd1);
      check($sformatf("vec%0d unit_op", i), 64'(unit_op_o), 64'(tv[i].op));
      wait_n = 0;
      do begin tick(); samp(); wait_n++; end while (!out_valid_o && wait_n < 20);
      check($sformatf("vec%0d latency", i), 64'(cyc - st_cyc), 64'(2 + tv[i].lat));
      check($sformatf("vec%0d result", i), out_result_o, tv[i].exp);
      check($sformatf("vec%0d tag", i), 64'(out_tag_o), 64'(tv[i].tag));
      check($sformatf("vec%0d mask", i), 64'(out_mask_o), 64'(tv[i].mask));
      out_ready_i = 1;
      tick();
      out_ready_i = 0;
      samp();
      check($sformatf("vec%0d valid drop", i), 64'(out_valid_o), 64'd0);
    end

    // Both lanes valid every cycle: grants must alternate 0,1,0,1.
    do_reset();
    u_lat = 2;
    out_ready_i = 1;
    grants.delete();
    both_cnt = 0;
    wait_n = 0;
    while (grants.size() < 4 && wait_n < 80) begin
      tick();
      drive_req(0, 2'b01, 32'd3, 32'd4, 8'h00, 20'h00100);
      drive_req(1, 2'b01, 32'd5, 32'd6, 8'h00, 20'h00200);
      samp();
      if (req0_ready_o && req1_ready_o) both_cnt++;
      if (req0_ready_o) grants.push_back(0);
      else if (req1_ready_o) grants.push_back(1);
      wait_n++;
    end
    check("rr grant count", 64'(grants.size()), 64'd4);
    check("rr double ready", 64'(both_cnt), 64'd0);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("rr grant%0d", i), 64'(grants[i]), 64'(i % 2));

    // Mispredict in BUSY: op drains, done swallowed, IDLE the cycle after done.
    do_reset();
    u_lat = 4;
    tick(); drive_req(0, 2'b00, 32'd9, 32'd9, 8'h04, 20'h00777); samp();
    check("drain ready0", 64'(req0_ready_o), 64'd1);
    tick(); req0_valid_i = 0; samp();
    check("drain start", 64'(unit_start_o), 64'd1);
    tick(); ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlSMTid_i = 3'd2; samp();
    for (int k = 3; k <= 6; k++) begin
      tick();
      drive_req(1, 2'b00, 32'd1, 32'd1, 8'h00, 20'h00001);
      if (k == 4) begin ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlSMTid_i = 3'd2; end
      samp();
      check($sformatf("drain k%0d valid", k), 64'(out_valid_o), 64'd0);
      check($sformatf("drain k%0d ready1", k), 64'(req1_ready_o), 64'(k == 6));
    end

    // Correct predict clears a mask bit; later mispredict in HOLD drops the op.
    do_reset();
    u_lat = 3;
    tick(); drive_req(0, 2'b00, 32'd2, 32'd3, 8'h06, 20'h0BEEF); samp();
    tick(); req0_valid_i = 0; samp();
    tick(); ctrlVerified_i = 1; ctrlSMTid_i = 3'd1; samp();
    tick(); samp();
    check("clr busy mask", 64'(out_mask_o), 64'h04);
    tick(); samp();
    tick(); samp();
    check("clr hold valid", 64'(out_valid_o), 64'd1);
    check("clr hold mask", 64'(out_mask_o), 64'h04);
    check("clr hold result", out_result_o, 64'd6);
    tick(); ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlSMTid_i = 3'd2;
    drive_req(1, 2'b00, 32'd1, 32'd1, 8'h00, 20'h00001); samp();
    check("hold kill same-cycle valid", 64'(out_valid_o), 64'd1);
    tick(); samp();
    check("hold kill valid drop", 64'(out_valid_o), 64'd0);
    check("hold kill ready1", 64'(req1_ready_o), 64'd1);

    // HOLD stalls 5 cycles, then out_ready coincides with a mispredict.
    do_reset();
    u_lat = 2;
    tick(); drive_req(0, 2'b01, 32'd1000, 32'd1000, 8'h10, 20'h0CAFE); samp();
    tick(); req0_valid_i = 0; samp();
    wait_n = 0;
    do begin tick(); samp(); wait_n++; end while (!out_valid_o && wait_n < 20);
    check("stall reach hold", 64'(out_valid_o), 64'd1);
    held = out_result_o;
    check("stall result", held, 64'd1000000);
    for (int k = 0; k < 5; k++) begin
      tick(); drive_req(1, 2'b00, 32'd1, 32'd1, 8'h00, 20'h00001); samp();
      check($sformatf("stall%0d valid", k), 64'(out_valid_o), 64'd1);
      check($sformatf("stall%0d result", k), out_result_o, held);
      check($sformatf("stall%0d ready1", k), 64'(req1_ready_o), 64'd0);
    end
    tick(); out_ready_i = 1; ctrlVerified_i = 1; ctrlMispredict_i = 1; ctrlSMTid_i = 3'd4; samp();
    tick(); out_ready_i = 0; samp();
    check("stall kill valid drop", 64'(out_valid_o), 64'd0);

    // Reset asserted in BUSY, then a lane1 request right after release.
    do_reset();
    u_lat = 5;
    tick(); drive_req(0, 2'b00, 32'd4, 32'd4, 8'h01, 20'h00044); samp();
    tick(); req0_valid_i = 0; samp();
    tick(); drive_req(1, 2'b10, 32'd50, 32'd5, 8'h00, 20'h00055); samp();
    #2 reset = 1'b0;
    u_cnt = 0;
    #1 check_all_zero("midreset");
    @(posedge clk); #2 reset = 1'b1;
    samp();
    check("post reset ready1", 64'(req1_ready_o), 64'd1);
    tick(); req1_valid_i = 0; samp();
    check("post reset start", 64'(unit_start_o), 64'd1);
    check("post reset a", 64'(unit_a_o), 64'd50);

    // Randomized run against a transaction-level model.
    do_reset();
    mrr = 0; fl = 0; dead = 0; res_av = 0; st_cyc = -1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      req0_valid_i = ($urandom_range(0, 1) == 1);
      req1_valid_i = ($urandom_range(0, 1) == 1);
      for (int l = 0; l < 2; l++) begin
        ra = $urandom; rb = $urandom;
        if (rb == 0) rb = 32'd1;
        rmask = 8'($urandom & $urandom & $urandom);
        rw = $urandom_range(0, 3);
        if (l == 0) begin
          req0_op_i = 2'(rw); req0_a_i = ra; req0_b_i = rb; req0_mask_i = rmask; req0_tag_i = 20'($urandom);
        end else begin
          req1_op_i = 2'(rw); req1_a_i = ra; req1_b_i = rb; req1_mask_i = rmask; req1_tag_i = 20'($urandom);
        end
      end
      ctrlVerified_i   = ($urandom_range(0, 3) == 0);
      ctrlMispredict_i = ($urandom_range(0, 2) == 0);
      ctrlSMTid_i      = 3'($urandom_range(0, 7));
      out_ready_i      = ($urandom_range(0, 1) == 1);
      u_lat            = $urandom_range(1, 6);
      done_now         = unit_done_i;
      samp();
      if (!fl) begin
        g = -1;
        if (req0_valid_i && req1_valid_i) g = mrr;
        else if (req0_valid_i) g = 0;
        else if (req1_valid_i) g = 1;
        check("rnd idle ready0", 64'(req0_ready_o), 64'(g == 0));
        check("rnd idle ready1", 64'(req1_ready_o), 64'(g == 1));
        check("rnd idle valid", 64'(out_valid_o), 64'd0);
        if (g >= 0) begin
          mrr = 1 - g;
          mop   = (g == 0) ? req0_op_i   : req1_op_i;
          ma    = (g == 0) ? req0_a_i    : req1_a_i;
          mb    = (g == 0) ? req0_b_i    : req1_b_i;
          mmask = (g == 0) ? req0_mask_i : req1_mask_i;
          mtag  = (g == 0) ? req0_tag_i  : req1_tag_i;
          if (!(ctrlVerified_i && ctrlMispredict_i && mmask[ctrlSMTid_i])) begin
            if (ctrlVerified_i && !ctrlMispredict_i) mmask[ctrlSMTid_i] = 1'b0;
            mres = mdu(mop, ma, mb);
            fl = 1; dead = 0; res_av = 0; st_cyc = cyc + 1;
          end
        end
      end else begin
        kill = ctrlVerified_i && ctrlMispredict_i && mmask[ctrlSMTid_i];
        check("rnd busy ready0", 64'(req0_ready_o), 64'd0);
        check("rnd busy ready1", 64'(req1_ready_o), 64'd0);
        check("rnd start", 64'(unit_start_o), 64'(cyc == st_cyc));
        if (cyc == st_cyc) begin
          check("rnd unit_op", 64'(unit_op_o), 64'(mop));
          check("rnd unit_a", 64'(unit_a_o), 64'(ma));
          check("rnd unit_b", 64'(unit_b_o), 64'(mb));
        end
        check("rnd valid", 64'(out_valid_o), 64'(res_av));
        if (res_av) begin
          check("rnd result", out_result_o, mres);
          check("rnd tag", 64'(out_tag_o), 64'(mtag));
          check("rnd mask", 64'(out_mask_o), 64'(mmask));
          if (kill || out_ready_i) fl = 0;
        end else if (dead) begin
          if (done_now) fl = 0;
        end else if (kill) begin
          if (done_now) fl = 0;
          else dead = 1;
        end else if (done_now) begin
          res_av = 1;
        end
        if (fl && ctrlVerified_i && !ctrlMispredict_i) mmask[ctrlSMTid_i] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
